// File: rtl/fxp_pkg.sv
// fxp_pkg: shared definitions for the fixed-point accumulator family.
//   - default Q2.14 configuration and derived max/min codes
//   - accumulator width derivation (acc_width)
//   - accumulator FSM state type
//   - sat_narrow(): clip a wide signed value to a DATA_WIDTH range
package fxp_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_FRAC_WIDTH = 14;
   localparam int unsigned DEF_INT_WIDTH  = 2;
   localparam int unsigned DEF_ACC_LEN    = 8;

   localparam logic [DEF_DATA_WIDTH-1:0] DEF_MAX_CODE = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
   localparam logic [DEF_DATA_WIDTH-1:0] DEF_MIN_CODE = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

   // Widest accumulator sat_narrow can handle.
   localparam int unsigned SAT_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      HOLD
   } state_t;

   typedef struct packed {
      logic [SAT_MAX_W-1:0] data;
      logic                 ovf;
      logic                 unf;
   } sat_t;

   // One guard bit per doubling of the sample count, plus one so that
   // negating the most negative code ACC_LEN times still fits.
   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned len);
      return dw + $clog2(len) + 1;
   endfunction

   // Clip a sign-extended accumulator value to the signed range of dw bits.
   // The low dw bits of .data hold the narrowed result.
   function automatic sat_t sat_narrow(input logic signed [SAT_MAX_W-1:0] acc,
                                       input int unsigned dw);
      sat_t                        r;
      logic signed [SAT_MAX_W-1:0] max_v;
      logic signed [SAT_MAX_W-1:0] min_v;
      max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (dw - 1));
      r     = '0;
      if (acc > max_v) begin
         r.data = max_v;
         r.ovf  = 1'b1;
      end else if (acc < min_v) begin
         r.data = min_v;
         r.unf  = 1'b1;
      end else begin
         r.data = acc;
      end
      return r;
   endfunction

endpackage

// File: rtl/fxp_saturate.sv
// fxp_saturate: combinational clip of a signed ACC_W value to DATA_WIDTH.
// Ports:
//   acc_in    in  ACC_W       signed wide value
//   data_out  out DATA_WIDTH  clipped value (truncated when in range)
//   ovf       out 1           value was above the max code
//   unf       out 1           value was below the min code
module fxp_saturate
   import fxp_pkg::*;
#(
   parameter int unsigned ACC_W      = 20,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic signed [ACC_W-1:0]      acc_in,
   output logic        [DATA_WIDTH-1:0] data_out,
   output logic                         ovf,
   output logic                         unf
);

   generate
      if (ACC_W > SAT_MAX_W || ACC_W <= DATA_WIDTH) begin : g_bad_width
         $error("fxp_saturate: need DATA_WIDTH < ACC_W <= %0d", SAT_MAX_W);
      end
   endgenerate

   sat_t res;
   logic unused_hi;

   always_comb begin
      res = sat_narrow(SAT_MAX_W'(acc_in), DATA_WIDTH);
   end

   assign data_out  = res.data[DATA_WIDTH-1:0];
   assign ovf       = res.ovf;
   assign unf       = res.unf;
   assign unused_hi = ^res.data[SAT_MAX_W-1:DATA_WIDTH];

endmodule

// File: rtl/fxp_accum.sv
// fxp_accum: block accumulator of signed Q(INT_WIDTH).(FRAC_WIDTH) samples.
// Adds or subtracts ACC_LEN samples at full precision, then presents one
// saturated DATA_WIDTH result with overflow/underflow flags.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   clear               sync abort of partial sum and pending result
//   in_valid/in_ready   input handshake; in_data sample, in_sub = subtract
//   out_valid/out_ready output handshake
//   out_data            saturated result
//   overflow_flag       result clipped to max (qualified by out_valid)
//   underflow_flag      result clipped to min (qualified by out_valid)
module fxp_accum
   import fxp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_WIDTH = DEF_FRAC_WIDTH,
   parameter int unsigned INT_WIDTH  = DEF_INT_WIDTH,
   parameter int unsigned ACC_LEN    = DEF_ACC_LEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  overflow_flag,
   output logic                  underflow_flag
);

   generate
      if (DATA_WIDTH != INT_WIDTH + FRAC_WIDTH) begin : g_bad_format
         $error("fxp_accum: DATA_WIDTH must equal INT_WIDTH + FRAC_WIDTH");
      end
      if (ACC_LEN < 1) begin : g_bad_len
         $error("fxp_accum: ACC_LEN must be >= 1");
      end
   endgenerate

   localparam int unsigned ACC_W = acc_width(DATA_WIDTH, ACC_LEN);
   localparam int unsigned CNT_W = $clog2(ACC_LEN + 1);

   state_t                  state, state_next;
   logic signed [ACC_W-1:0] acc, acc_next;
   logic signed [ACC_W-1:0] sample_ext, addend, base, sum;
   logic [CNT_W-1:0]        count, count_next;
   logic                    accept;
   logic                    load_out;
   logic [DATA_WIDTH-1:0]   sat_data;
   logic                    sat_ovf, sat_unf;

   // in_ready is forced low while reset is held, not just after the edge.
   assign in_ready  = rst_n && (state != HOLD);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   assign sample_ext = {{(ACC_W-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
   assign addend     = in_sub ? -sample_ext : sample_ext;
   // The first sample of a block starts from zero, so acc need not be
   // cleared on the way into IDLE for correctness.
   assign base       = (state == IDLE) ? '0 : acc;
   assign sum        = base + addend;

   // Saturation sits on the next-value path so the clipped result is
   // registered on the same edge that enters HOLD.
   fxp_saturate #(
      .ACC_W      (ACC_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sat (
      .acc_in   (sum),
      .data_out (sat_data),
      .ovf      (sat_ovf),
      .unf      (sat_unf)
   );

   always_comb begin
      state_next = state;
      acc_next   = acc;
      count_next = count;
      load_out   = 1'b0;
      if (clear) begin
         state_next = IDLE;
         acc_next   = '0;
         count_next = '0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (accept) begin
                  acc_next   = sum;
                  count_next = (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
                  if (count_next == CNT_W'(ACC_LEN)) begin
                     state_next = HOLD;
                     load_out   = 1'b1;
                  end else begin
                     state_next = ACC;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_next = IDLE;
                  acc_next   = '0;
                  count_next = '0;
               end
            end
            default: begin
               state_next = IDLE;
               acc_next   = '0;
               count_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         acc            <= '0;
         count          <= '0;
         out_data       <= '0;
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         count <= count_next;
         if (load_out) begin
            out_data       <= sat_data;
            overflow_flag  <= sat_ovf;
            underflow_flag <= sat_unf;
         end
      end
   end

endmodule

// File: tb/tb_fxp_accum.sv
// tb_fxp_accum: self-checking bench for fxp_accum (default build and an
// ACC_LEN = 1 build). Expected results come from an integer sum of the
// block's samples clipped to the Q2.14 range.
module tb_fxp_accum;

   localparam int unsigned N = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sub = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_data = '0;
   logic        in_ready, out_valid, ovf, unf;
   logic [15:0] out_data;

   logic        s_in_valid = 1'b0;
   logic        s_in_sub = 1'b0;
   logic        s_out_ready = 1'b1;
   logic [15:0] s_in_data = '0;
   logic        s_in_ready, s_out_valid, s_ovf, s_unf;
   logic [15:0] s_out_data;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [15:0] blk_d[N];
   logic        blk_s[N];

   always #5 clk = ~clk;

   fxp_accum dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_sub         (in_sub),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .overflow_flag  (ovf),
      .underflow_flag (unf)
   );

   fxp_accum #(.ACC_LEN(1)) dut1 (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (1'b0),
      .in_valid       (s_in_valid),
      .in_ready       (s_in_ready),
      .in_data        (s_in_data),
      .in_sub         (s_in_sub),
      .out_valid      (s_out_valid),
      .out_ready      (s_out_ready),
      .out_data       (s_out_data),
      .overflow_flag  (s_ovf),
      .underflow_flag (s_unf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: exact integer sum clipped to the signed 16-bit range.
   task automatic model_result(input longint sum, output logic [15:0] d,
                               output logic o, output logic u);
      if (sum > 32767) begin
         d = 16'h7FFF; o = 1'b1; u = 1'b0;
      end else if (sum < -32768) begin
         d = 16'h8000; o = 1'b0; u = 1'b1;
      end else begin
         d = 16'(sum); o = 1'b0; u = 1'b0;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [15:0] d, input logic s);
      int unsigned n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_sub   = s;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 'x;
      in_sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic fill_const(input logic [15:0] d, input logic s);
      for (int i = 0; i < N; i++) begin
         blk_d[i] = d;
         blk_s[i] = s;
      end
   endtask

   // Send blk_d/blk_s, check the result one clock after the last accept,
   // optionally hold out_ready low for 'hold' cycles, then consume it.
   task automatic run_block(input string tag, input bit gaps, input int unsigned hold);
      longint      sum = 0;
      logic [15:0] ed;
      logic        eo, eu;
      out_ready = (hold == 0);
      for (int i = 0; i < N; i++) begin
         sum += blk_s[i] ? -longint'($signed(blk_d[i])) : longint'($signed(blk_d[i]));
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send(blk_d[i], blk_s[i]);
      end
      model_result(sum, ed, eo, eu);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(out_data), 32'(ed));
      check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
      check_eq({tag, "_unf"}, 32'(unf), 32'(eu));
      for (int c = 0; c < int'(hold); c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 16'($urandom);
         in_sub   = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check_eq({tag, "_hold_data"}, 32'(out_data), 32'(ed));
         check_eq({tag, "_hold_flags"}, 32'({ovf, unf}), 32'({eo, eu}));
         check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      in_data   = 'x;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, "_done"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Async reset with the clock low: outputs must be cleared without an edge.
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_rdy", 32'(in_ready), 32'd0);
      check_eq("rst_data", 32'(out_data), 32'd0);
      check_eq("rst_flags", 32'({ovf, unf}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_rdy", 32'(in_ready), 32'd1);

      // Directed blocks.
      fill_const(16'h0800, 1'b0);
      run_block("add_0p125", 1'b0, 0);
      fill_const(16'h3000, 1'b0);
      run_block("ovf_6p0", 1'b0, 0);
      fill_const(16'h8000, 1'b0);
      run_block("unf_m16", 1'b0, 0);
      fill_const(16'h0000, 1'b0);
      blk_d[0] = 16'h8000;
      blk_s[0] = 1'b1;
      run_block("sub_min", 1'b0, 0);

      // Backpressure, then a normal block afterwards.
      fill_const(16'h0800, 1'b0);
      run_block("bp", 1'b0, 5);
      run_block("bp_after", 1'b0, 0);

      // Clear after three accepts; sample in the clear cycle is dropped.
      for (int i = 0; i < 3; i++) send(16'h2000, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h7000;
      in_sub   = 1'b0;
      check_eq("clr_rdy", 32'(in_ready), 32'd1);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      check_eq("clr_valid", 32'(out_valid), 32'd0);
      fill_const(16'h0400, 1'b0);
      run_block("clr_next", 1'b0, 0);

      // Reset mid-ACC.
      for (int i = 0; i < 3; i++) send(16'h0800, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rs_acc_rdy", 32'(in_ready), 32'd0);
      check_eq("rs_acc_valid", 32'(out_valid), 32'd0);
      check_eq("rs_acc_data", 32'(out_data), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Reset mid-HOLD.
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) send(16'h3000, 1'b0);
      check_eq("rs_hold_pre", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rs_hold_valid", 32'(out_valid), 32'd0);
      check_eq("rs_hold_data", 32'(out_data), 32'd0);
      check_eq("rs_hold_flags", 32'({ovf, unf}), 32'd0);
      check_eq("rs_hold_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      fill_const(16'h0800, 1'b0);
      run_block("rs_clean", 1'b0, 0);

      // ACC_LEN = 1 build: subtracting the min code saturates high.
      s_in_valid = 1'b1;
      s_in_data  = 16'h8000;
      s_in_sub   = 1'b1;
      check_eq("l1_rdy", 32'(s_in_ready), 32'd1);
      @(negedge clk);
      s_in_valid = 1'b0;
      check_eq("l1_valid", 32'(s_out_valid), 32'd1);
      check_eq("l1_data", 32'(s_out_data), 32'h7FFF);
      check_eq("l1_flags", 32'({s_ovf, s_unf}), 32'b10);
      @(negedge clk);
      check_eq("l1_done", 32'(s_out_valid), 32'd0);
      s_in_valid = 1'b1;
      s_in_data  = 16'hC000;
      s_in_sub   = 1'b0;
      @(negedge clk);
      s_in_valid = 1'b0;
      check_eq("l1b_data", 32'(s_out_data), 32'hC000);
      check_eq("l1b_flags", 32'({s_ovf, s_unf}), 32'b00);
      @(negedge clk);

      // Randomized blocks with gaps and backpressure.
      for (int b = 0; b < 30; b++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0: blk_d[i] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
               1: blk_d[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
               default: blk_d[i] = 16'($urandom);
            endcase
            blk_s[i] = 1'($urandom_range(0, 1));
         end
         run_block($sformatf("rnd%0d", b), 1'b1, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
